// File: rtl/evolve_anim.sv
// Evolution-sequence engine: latches a species, flashes base/evolved sprites at a
// frame-synchronous, accelerating rate, then holds the evolved sprite until confirmed.
module evolve_anim #(
   parameter int          X_POS        = 484,
   parameter int          Y_POS        = 332,
   parameter int          SPRITE_W     = 56,
   parameter int          SPRITE_H     = 56,
   parameter int          FRAMES_INIT  = 16,
   parameter int          FRAMES_MIN   = 2,
   parameter int          TOTAL_FRAMES = 200,
   parameter logic [7:0]  MAX_SPECIES  = 8'd150,
   parameter int          SILHOUETTE   = 1,
   parameter logic [11:0] KEY_COLOR    = 12'h000,
   parameter int          ROM_LAT      = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        start_in,
   input  logic        select_in,
   input  logic        cancel_in,
   input  logic [7:0]  species_in,
   input  logic [11:0] sprite_pixel_in,
   output logic [7:0]  sprite_sel_out,
   output logic        busy_out,
   output logic        done_out,
   output logic        evolved_out,
   output logic [7:0]  species_out,
   output logic [11:0] pixel_out
);

   localparam logic [15:0] INIT  = 16'(FRAMES_INIT);
   localparam logic [15:0] FMIN  = 16'(FRAMES_MIN);
   localparam logic [15:0] TOTAL = 16'(TOTAL_FRAMES);
   localparam logic [10:0] X_LO  = 11'(X_POS);
   localparam logic [10:0] X_HI  = 11'(X_POS + SPRITE_W);
   localparam logic [9:0]  Y_LO  = 10'(Y_POS);
   localparam logic [9:0]  Y_HI  = 10'(Y_POS + SPRITE_H);

   typedef enum logic [1:0] {IDLE, FLASH, HOLD, FINISH} state_t;

   state_t      state;
   logic [7:0]  base;
   logic [15:0] frame_cnt, toggle_cnt, interval;
   logic        show_evo;
   logic        tick, in_win;

   assign tick   = (hcount_in == 11'd0) && (vcount_in == 10'd0);
   assign in_win = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                   (vcount_in >= Y_LO) && (vcount_in < Y_HI);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         base           <= 8'd0;
         frame_cnt      <= 16'd0;
         toggle_cnt     <= 16'd0;
         interval       <= 16'd0;
         show_evo       <= 1'b0;
         sprite_sel_out <= 8'd0;
         busy_out       <= 1'b0;
         done_out       <= 1'b0;
         evolved_out    <= 1'b0;
         species_out    <= 8'd0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               // busy drops one cycle after the done pulse, not with it
               busy_out <= start_in;
               if (start_in) begin
                  base <= species_in;
                  if (species_in >= MAX_SPECIES) begin
                     state       <= FINISH;
                     evolved_out <= 1'b0;
                     species_out <= species_in;
                  end else begin
                     state          <= FLASH;
                     frame_cnt      <= 16'd0;
                     toggle_cnt     <= 16'd0;
                     interval       <= INIT;
                     show_evo       <= 1'b0;
                     sprite_sel_out <= species_in;
                  end
               end
            end
            FLASH: begin
               if (cancel_in) begin
                  state       <= FINISH;
                  evolved_out <= 1'b0;
                  species_out <= base;
               end else if (tick) begin
                  frame_cnt <= frame_cnt + 16'd1;
                  if (toggle_cnt + 16'd1 == interval) begin
                     toggle_cnt     <= 16'd0;
                     interval       <= (interval > FMIN) ? interval - 16'd1 : FMIN;
                     show_evo       <= ~show_evo;
                     sprite_sel_out <= base + {7'd0, ~show_evo};
                  end else begin
                     toggle_cnt <= toggle_cnt + 16'd1;
                  end
                  // end of flashing overrides a coincident toggle
                  if (frame_cnt + 16'd1 == TOTAL) begin
                     state          <= HOLD;
                     show_evo       <= 1'b1;
                     sprite_sel_out <= base + 8'd1;
                  end
               end
            end
            HOLD: begin
               show_evo <= 1'b1;
               if (select_in) begin
                  state       <= FINISH;
                  evolved_out <= 1'b1;
                  species_out <= base + 8'd1;
               end
            end
            FINISH: begin
               done_out <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // window/flash flags delayed to line up with the ROM's read latency
   logic [ROM_LAT:1] win_pipe, flash_pipe;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         win_pipe   <= '0;
         flash_pipe <= '0;
         pixel_out  <= 12'h000;
      end else begin
         win_pipe[1]   <= in_win;
         flash_pipe[1] <= (state == FLASH);
         for (int i = 2; i <= ROM_LAT; i++) begin
            win_pipe[i]   <= win_pipe[i-1];
            flash_pipe[i] <= flash_pipe[i-1];
         end
         if (win_pipe[ROM_LAT] && (state == FLASH || state == HOLD)) begin
            if (SILHOUETTE != 0 && flash_pipe[ROM_LAT] && sprite_pixel_in != KEY_COLOR)
               pixel_out <= 12'hFFF;
            else
               pixel_out <= sprite_pixel_in;
         end else begin
            pixel_out <= 12'h000;
         end
      end
   end

endmodule

// File: tb/tb_evolve_anim.sv
// Randomized scoreboard bench for evolve_anim: stimulus pushes expectations from a
// behavioural model, a negedge monitor pops and compares them against the DUT.
module tb_evolve_anim;
   localparam int TOTAL  = 200;
   localparam int F_INIT = 16;
   localparam int F_MIN  = 2;
   localparam int P_IDLE = 0, P_FLASH = 1, P_HOLD = 2, P_FINISH = 3;

   logic        clk_in = 1'b0;
   logic        rst_in, start_in, select_in, cancel_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [7:0]  species_in;
   logic [11:0] sprite_pixel_in;
   logic [7:0]  sprite_sel_out, species_out;
   logic        busy_out, done_out, evolved_out;
   logic [11:0] pixel_out;

   always #5 clk_in = ~clk_in;

   evolve_anim dut (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .start_in(start_in), .select_in(select_in), .cancel_in(cancel_in),
      .species_in(species_in), .sprite_pixel_in(sprite_pixel_in),
      .sprite_sel_out(sprite_sel_out), .busy_out(busy_out), .done_out(done_out),
      .evolved_out(evolved_out), .species_out(species_out), .pixel_out(pixel_out)
   );

   typedef struct {int due; logic [11:0] pix; logic busy;} cexp_t;
   typedef struct {int due; logic [7:0] sel;} sexp_t;
   typedef struct {int due; logic ev; logic [7:0] sp;} dexp_t;
   cexp_t cq[$];
   sexp_t sq[$];
   dexp_t dq[$];

   int cyc = 0;
   int checks = 0, errors = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h cycle %0d", name, act, exp, cyc);
      end
   endtask

   // monitor
   cexp_t ce;
   sexp_t se;
   dexp_t de;
   always @(negedge clk_in) begin
      while (cq.size() > 0 && cq[0].due <= cyc) begin
         ce = cq.pop_front();
         if (ce.due == cyc) begin
            chk("pixel_out", pixel_out, ce.pix);
            chk("busy_out", busy_out, ce.busy);
         end
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
         se = sq.pop_front();
         if (se.due == cyc) chk("sprite_sel", sprite_sel_out, se.sel);
      end
      if (done_out === 1'b1) begin
         if (dq.size() == 0) chk("done_out", done_out, 0);
         else begin
            de = dq.pop_front();
            chk("done_cycle", cyc, de.due);
            chk("evolved_out", evolved_out, de.ev);
            chk("species_out", species_out, de.sp);
         end
      end else if (dq.size() > 0 && dq[0].due < cyc) begin
         de = dq.pop_front();
         chk("done_out", done_out, 1);
      end
   end

   // reference model: toggle points are cumulative sums of shrinking intervals
   function automatic bit show_after(input int t);
      int pos = 0, iv = F_INIT, n = 0;
      if (t >= TOTAL) return 1'b1;
      while (1) begin
         pos += iv;
         if (pos > t) break;
         n++;
         iv = (iv - 1 < F_MIN) ? F_MIN : iv - 1;
      end
      return n[0];
   endfunction

   int         mph = P_IDLE;
   int         mfc = 0;
   logic [7:0] mbase = 8'd0;
   bit         w1, w2, f1, f2;

   task automatic step(input logic [10:0] h, input logic [9:0] v, input logic [11:0] pix,
                       input bit st, input bit sl, input bit cn, input bit rs,
                       input logic [7:0] sp);
      bit tick, w;
      int nph;
      logic [11:0] ep;
      hcount_in = h; vcount_in = v; sprite_pixel_in = pix;
      start_in = st; select_in = sl; cancel_in = cn; rst_in = rs; species_in = sp;
      tick = (h == 0 && v == 0);
      w = (h >= 484 && h < 540 && v >= 332 && v < 388);
      if (rs) begin
         nph = P_IDLE;
         w1 = 0; w2 = 0; f1 = 0; f2 = 0;
         dq.delete();
         cq.push_back('{cyc + 1, 12'h000, 1'b0});
         sq.push_back('{cyc + 1, 8'h00});
      end else begin
         ep = 12'h000;
         if (w2 && (mph == P_FLASH || mph == P_HOLD))
            ep = (f2 && pix != 12'h000) ? 12'hFFF : pix;
         nph = mph;
         case (mph)
            P_IDLE: if (st) begin
               mbase = sp;
               if (sp >= 8'd150) begin
                  nph = P_FINISH;
                  dq.push_back('{cyc + 2, 1'b0, sp});
               end else begin
                  nph = P_FLASH;
                  mfc = 0;
                  sq.push_back('{cyc + 1, sp});
               end
            end
            P_FLASH: if (cn) begin
               nph = P_FINISH;
               dq.push_back('{cyc + 2, 1'b0, mbase});
            end else if (tick) begin
               mfc++;
               if (mfc == TOTAL) nph = P_HOLD;
               sq.push_back('{cyc + 1, mbase + 8'(show_after(mfc))});
            end
            P_HOLD: if (sl) begin
               nph = P_FINISH;
               dq.push_back('{cyc + 2, 1'b1, mbase + 8'd1});
            end else if (tick) begin
               sq.push_back('{cyc + 1, mbase + 8'd1});
            end
            default: nph = P_IDLE;
         endcase
         cq.push_back('{cyc + 1, ep, (nph != P_IDLE) || (mph == P_FINISH)});
         w2 = w1; w1 = w; f2 = f1; f1 = (mph == P_FLASH);
      end
      mph = nph;
      @(posedge clk_in); #1;
   endtask

   task automatic rnd_coord(output logic [10:0] h, output logic [9:0] v);
      case ($urandom_range(0, 5))
         0: begin h = 11'd484; v = 10'd332; end
         1: begin h = 11'd483; v = 10'd332; end
         2: begin h = 11'd539; v = 10'd387; end
         3: begin h = 11'd540; v = 10'd350; end
         4: begin h = 11'($urandom_range(484, 539)); v = 10'($urandom_range(332, 387)); end
         default: begin h = 11'($urandom_range(1, 799)); v = 10'($urandom_range(0, 524)); end
      endcase
   endtask

   function automatic logic [11:0] rnd_pix();
      case ($urandom_range(0, 2))
         0: return 12'h3A5;
         1: return 12'h000;
         default: return 12'($urandom);
      endcase
   endfunction

   task automatic idle(input int n);
      logic [10:0] h;
      logic [9:0]  v;
      for (int i = 0; i < n; i++) begin
         rnd_coord(h, v);
         step(h, v, rnd_pix(), 0, 0, 0, 0, 8'($urandom));
      end
   endtask

   task automatic reset_checks();
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      chk("rst_evolved", evolved_out, 0);
      chk("rst_species", species_out, 0);
      chk("rst_sel", sprite_sel_out, 0);
      chk("rst_pixel", pixel_out, 0);
   endtask

   // cancel_tick > 0: cancel on that tick cycle; < 0: cancel mid-frame after tick |n|
   task automatic evolve(input logic [7:0] sp, input int cancel_tick, input int rst_tick,
                         input bit noise);
      logic [10:0] h;
      logic [9:0]  v;
      bit cmid;
      rnd_coord(h, v);
      step(h, v, rnd_pix(), 1, 0, 0, 0, sp);
      chk("busy_after_start", busy_out, 1);
      if (sp >= 8'd150) begin idle(4); return; end
      for (int t = 1; t <= TOTAL; t++) begin
         if (t == rst_tick) begin
            step(11'd0, 10'd0, rnd_pix(), 0, 0, 0, 1, 8'd0);
            reset_checks();
            idle(2);
            return;
         end
         step(11'd0, 10'd0, rnd_pix(), 0, 0, (t == cancel_tick), 0, sp);
         if (t == cancel_tick) begin idle(4); return; end
         for (int k = 0; k < 5; k++) begin
            rnd_coord(h, v);
            cmid = (-cancel_tick == t) && (k == 2);
            step(h, v, rnd_pix(), noise && t < TOTAL && $urandom_range(0, 7) == 0,
                 noise && t < TOTAL && $urandom_range(0, 7) == 0, cmid, 0, 8'($urandom));
            if (cmid) begin idle(4); return; end
         end
      end
      // in HOLD, cancel is ignored
      for (int f = 0; f < 2; f++) begin
         step(11'd0, 10'd0, rnd_pix(), 0, 0, 1, 0, sp);
         for (int k = 0; k < 5; k++) begin
            rnd_coord(h, v);
            step(h, v, rnd_pix(), 0, 0, 1'($urandom), 0, 8'($urandom));
         end
      end
      rnd_coord(h, v);
      step(h, v, rnd_pix(), 0, 1, 0, 0, sp);
      idle(4);
   endtask

   initial begin
      rst_in = 1'b1; start_in = 0; select_in = 0; cancel_in = 0;
      hcount_in = 0; vcount_in = 0; species_in = 0; sprite_pixel_in = 0;
      @(posedge clk_in); #1;
      step(11'd1, 10'd1, 12'h000, 0, 0, 0, 1, 8'd0);
      step(11'd1, 10'd1, 12'h000, 0, 0, 0, 1, 8'd0);
      reset_checks();
      idle(3);
      evolve(8'd4, 0, 0, 1);
      evolve(8'd4, 50, 0, 0);
      evolve(8'd150, 0, 0, 0);
      evolve(8'($urandom_range(151, 255)), 0, 0, 0);
      evolve(8'($urandom_range(0, 149)), -int'($urandom_range(1, 199)), 0, 1);
      evolve(8'd20, 0, 77, 1);
      evolve(8'd4, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         evolve(8'($urandom_range(0, 149)), int'($urandom_range(1, 199)), 0, 1);
      evolve(8'd149, 0, 0, 1);
      idle(6);
      chk("done_queue_empty", dq.size(), 0);
      chk("sel_queue_empty", sq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/evolve_anim.md
# evolve_anim

Parametrised evolution-sequence engine for the battle/party screen. On a start pulse it latches a species index, then runs a frame-synchronous flashing animation between the base and evolved sprite, flashing faster as it goes. It then shows the evolved sprite until the player confirms. The player can cancel while flashing. The block drives the sprite-ROM select, gates and optionally silhouettes the returned pixel for the sprite window, and reports the outcome to the game FSM.

## Interface
Parameters:
- X_POS, 484: left edge of sprite window (hcount)
- Y_POS, 332: top edge of sprite window (vcount)
- SPRITE_W, 56: window width, pixels
- SPRITE_H, 56: window height, pixels
- FRAMES_INIT, 16: frames per flash toggle at sequence start
- FRAMES_MIN, 2: floor on frames per toggle
- TOTAL_FRAMES, 200: flashing length in frames
- MAX_SPECIES, 8'd150: species indices at or above this cannot evolve
- SILHOUETTE, 1: 1 = opaque pixels drawn 12'hFFF while flashing
- KEY_COLOR, 12'h000: transparent colour of the sprite ROM
- ROM_LAT, 2: sprite ROM read latency, cycles

Ports:
- clk_in, input, 1: pixel clock
- rst_in, input, 1: synchronous, active-high reset
- hcount_in, input, 11: current pixel x
- vcount_in, input, 10: current pixel y
- start_in, input, 1: one-cycle request to begin evolution
- select_in, input, 1: confirm button, level
- cancel_in, input, 1: abort button, level
- species_in, input, 8: species to evolve, sampled on accepted start
- sprite_pixel_in, input, 12: ROM pixel, valid ROM_LAT cycles after sel/coord
- sprite_sel_out, output, 8: species index currently displayed
- busy_out, output, 1: high outside IDLE
- done_out, output, 1: one-cycle completion pulse
- evolved_out, output, 1: outcome of last sequence (1 = evolved)
- species_out, output, 8: resulting species of last sequence
- pixel_out, output, 12: window pixel, 0 outside window or when idle

## Operation
- Frame tick = (hcount_in==0 && vcount_in==0). All animation counters advance only on the tick.
- States: IDLE, FLASH, HOLD, FINISH.
- IDLE:
  - start_in=1 latches base=species_in.
  - If base >= MAX_SPECIES, go to FINISH with evolved_out=0 and species_out=base.
  - Otherwise go to FLASH with frame_cnt=0, toggle_cnt=0, interval=FRAMES_INIT, show_evo=0.
- FLASH, on each tick:
  - frame_cnt+1 and toggle_cnt+1.
  - When toggle_cnt+1 == interval: invert show_evo, set toggle_cnt=0, set interval=max(interval-1, FRAMES_MIN).
  - When frame_cnt+1 == TOTAL_FRAMES: go to HOLD with show_evo=1.
- cancel_in in FLASH, on any cycle, goes to FINISH with evolved_out=0 and species_out=base. Cancel takes priority over a same-cycle tick.
- HOLD: show_evo=1. select_in goes to FINISH with evolved_out=1 and species_out=base+1. cancel_in is ignored in HOLD.
- FINISH: asserts done_out for exactly one cycle, then returns to IDLE. evolved_out and species_out hold until the next FINISH.
- sprite_sel_out = base + show_evo in FLASH and HOLD. Holds its last value in IDLE.
- start_in outside IDLE is ignored. select_in in FLASH is ignored.
- Counters are 16 bits wide. TOTAL_FRAMES and FRAMES_INIT must be < 65536.

## Timing
- Window test: X_POS <= hcount < X_POS+SPRITE_W and Y_POS <= vcount < Y_POS+SPRITE_H. Evaluated each cycle.
- The window flag and a flashing flag (state==FLASH) are delayed ROM_LAT cycles so they align with sprite_pixel_in.
- pixel_out is registered, so total latency from hcount/vcount to pixel_out is ROM_LAT+1 cycles. Value:
  - 0 if the delayed flag is not in-window, or the state is IDLE or FINISH.
  - Otherwise 12'hFFF if SILHOUETTE=1, flashing, and sprite_pixel_in != KEY_COLOR.
  - Otherwise sprite_pixel_in.
- start accepted → busy_out high next cycle.
- FINISH → done_out high for one cycle, busy_out low the following cycle.
- Reset at any time: IDLE, all counters 0, pixel_out=0, busy_out=0, done_out=0, evolved_out=0, species_out=0, sprite_sel_out=0, delay lines cleared.

## Test plan
- Normal evolve: species_in=8'd4, start, 200 ticks, then select → sprite_sel_out alternates 4/5 with toggles at ticks 16, 31, 45, …, then 5 in HOLD. done_out is a single pulse with evolved_out=1 and species_out=5.
- Cancel: species 4, assert cancel_in on tick 50 in the same cycle as the tick → FINISH, evolved_out=0, species_out=4, frame_cnt did not advance.
- Refused: species_in=8'd150 → done_out 2 cycles after start, evolved_out=0, species_out=150, no flashing.
- Pixel path, ROM_LAT=2: while flashing, drive sprite_pixel_in=12'h3A5 at (484,332) → pixel_out=12'hFFF 3 cycles later. The same stimulus in HOLD → 12'h3A5. KEY_COLOR gives 0 in either state. Coordinate (483,332) always gives 0.
- Interval floor: FRAMES_INIT=4, FRAMES_MIN=2 → toggle spacing is 4, 3, 2, 2, 2 ticks.
- Robustness: start pulse during FLASH and select during FLASH are ignored. rst_in mid-FLASH clears all outputs next cycle, and a new start then works.
